// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the word-only data lut_ram.
// Loads read the RAM asynchronously in IDLE and respond one cycle later.
// Sub-word stores use a one-cycle read-merge-write (MERGE) before responding.
// Build option: define LSU_MISALIGN_ERR_EN to make misaligned accesses errors;
// when undefined, low address bits are forced aligned and the access proceeds.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH),
  localparam int unsigned XLEN     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [XLEN-1:0]   ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [XLEN-1:0]   ram_rd_data
);

`ifdef LSU_MISALIGN_ERR_EN
  localparam bit MisalignErr = 1'b1;
`else
  localparam bit MisalignErr = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StMerge, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [ADDR_W-1:0] req_waddr;
  logic [1:0]        req_off;
  logic              req_illegal;
  logic              req_misal;
  logic              req_oor;
  logic              req_err;
  logic [XLEN-1:0]   merged;

  assign req_waddr = req_addr[ADDR_W+1:2];
  assign req_oor   = {2'b00, req_addr[XLEN-1:2]} >= XLEN'(MEM_DEPTH);

  // Byte-to-word extraction with sign/zero extension for loads.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [1:0]      off,
                                               input logic [2:0]      f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h0, b};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = word;
    endcase
  endfunction

  // Decode funct3 legality, alignment, and the effective (forced-aligned) offset.
  always_comb begin
    req_illegal = 1'b0;
    req_misal   = 1'b0;
    req_off     = req_addr[1:0];
    case (req_funct3)
      3'b000: ;
      3'b100: req_illegal = req_we;
      3'b001, 3'b101: begin
        req_illegal = req_we & req_funct3[2];
        req_misal   = req_addr[0];
        req_off     = {req_addr[1], 1'b0};
      end
      3'b010: begin
        req_misal = |req_addr[1:0];
        req_off   = 2'b00;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  assign req_err = req_oor | req_illegal | (MisalignErr & req_misal);

  // Replace the addressed byte/half of the current RAM word with the latched store data.
  always_comb begin
    merged = ram_rd_data;
    case (funct3_q)
      3'b000:  merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
      3'b001:  merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Next-state, latch and response logic.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_rd_addr = req_waddr;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = StResp;
          end else if (req_we) begin
            waddr_d  = req_waddr;
            off_d    = req_off;
            funct3_d = req_funct3;
            wdata_d  = req_wdata;
            state_d  = StMerge;
          end else begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = load_ext(ram_rd_data, req_off, req_funct3);
            state_d     = StResp;
          end
        end
      end
      StMerge: begin
        ram_rd_addr = waddr_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-request registers; reset drops any pending store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign ram_wr_en   = (state_q == StMerge);
  assign ram_wr_addr = waddr_q;
  assign ram_wr_data = merged;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a behavioural lut_ram.
module tb_lsu_mem_ctrl;
  localparam int unsigned MemDepth = 1024;
  localparam int unsigned AddrW    = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [2:0]       req_funct3 = 3'b010;
  logic [31:0]      req_addr = 32'h0;
  logic [31:0]      req_wdata = 32'h0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             ram_wr_en;
  logic [AddrW-1:0] ram_wr_addr;
  logic [31:0]      ram_wr_data;
  logic [AddrW-1:0] ram_rd_addr;
  logic [31:0]      ram_rd_data;

  logic [31:0] mem [MemDepth];
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;

  lsu_mem_ctrl #(.MEM_DEPTH(MemDepth)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // lut_ram model: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_count         <= wr_count + 1;
    end
  end
  assign ram_rd_data = mem[ram_rd_addr];

  // Drive one request from IDLE, wait (bounded) for its response, then retire it.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic er);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h got rsp_valid=%b need 1", addr, rsp_valid);
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b need 0", rsp_valid); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b need 0", ram_wr_en); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b need 1", req_ready); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h need 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b need 0", rsp_err); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er; int wc;
    wc = wr_count;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d need 2", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_rsp got %h/%b need 0/0", rd, er); end
    checks++; if (wr_count - wc !== 1) begin errors++; $display("FAIL sw_writes got %0d need 1", wr_count - wc); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL lw_latency got %0d need 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h need deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b need 0", er); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 3'b000, 32'h12, 32'hFFFFFF5A, lat, rd, er);
    checks++; if (mem[4] !== 32'hDE5ABEEF) begin errors++; $display("FAIL sb_merge got %h need de5abeef", mem[4]); end
    issue(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_13 got %h need ffffffde", rd); end
    issue(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu_13 got %h need 000000de", rd); end
    issue(1'b0, 3'b000, 32'h12, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000005A) begin errors++; $display("FAIL lb_12 got %h need 0000005a", rd); end
    issue(1'b0, 3'b000, 32'h10, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_10 got %h need ffffffef", rd); end
    issue(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL lbu_11 got %h need 000000be", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 3'b010, 32'h14, 32'hCAFE1234, lat, rd, er);
    issue(1'b1, 3'b001, 32'h16, 32'h12348001, lat, rd, er);
    checks++; if (mem[5] !== 32'h80011234) begin errors++; $display("FAIL sh_merge got %h need 80011234", mem[5]); end
    issue(1'b0, 3'b001, 32'h16, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_16 got %h need ffff8001", rd); end
    issue(1'b0, 3'b101, 32'h16, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_16 got %h need 00008001", rd); end
    issue(1'b0, 3'b101, 32'h14, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu_14 got %h need 00001234", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; int wc;
    wc = wr_count;
    issue(1'b1, 3'b010, 32'h1000, 32'h55555555, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sw_oor got %b/%h need 1/0", er, rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency got %0d need 1", lat); end
    issue(1'b0, 3'b010, 32'h1000, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL lw_oor got %b need 1", er); end
    issue(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ld_f3_011 got %b/%h need 1/0", er, rd); end
    issue(1'b1, 3'b100, 32'h10, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL st_f3_100 got %b need 1", er); end
    checks++; if (wr_count !== wc) begin errors++; $display("FAIL err_no_write got %0d need %0d", wr_count, wc); end
    issue(1'b0, 3'b010, 32'h11, 32'h0, lat, rd, er);
`ifdef LSU_MISALIGN_ERR_EN
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misal got %b/%h need 1/0", er, rd); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'hDE5ABEEF) begin errors++; $display("FAIL lw_misal got %b/%h need 0/de5abeef", er, rd); end
`endif
    issue(1'b0, 3'b001, 32'h17, 32'h0, lat, rd, er);
`ifdef LSU_MISALIGN_ERR_EN
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh_misal got %b/%h need 1/0", er, rd); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_misal got %b/%h need 0/ffff8001", er, rd); end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    first = rsp_rdata;
    checks++; if (first !== 32'hDE5ABEEF) begin errors++; $display("FAIL bp_data got %h need de5abeef", first); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== first || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b d=%h rdy=%b need 1/%h/0", i, rsp_valid, rsp_rdata,
                 req_ready, first);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b need 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    int acc; int rsp;
    acc = 0; rsp = 0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; rsp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (req_ready) acc++;
      if (rsp_valid) begin
        rsp++;
        checks++; if (rsp_rdata !== 32'h80011234) begin errors++; $display("FAIL b2b_data got %h need 80011234", rsp_rdata); end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++; if (acc !== 4 || rsp !== 4) begin errors++; $display("FAIL b2b_rate got %0d/%0d need 4/4", acc, rsp); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 3'b010, 32'h20, 32'h11111111, lat, rd, er);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h22222222; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL abort_in_merge got %b need 1", ram_wr_en); end
    rst = 1'b1;
    #1;
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en got %b need 0", ram_wr_en); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem[8] !== 32'h11111111) begin errors++; $display("FAIL abort_mem got %h need 11111111", mem[8]); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_rsp got v=%b rdy=%b need 0/1", rsp_valid, req_ready); end
    issue(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL abort_readback got %h need 11111111", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the data-memory lut_ram in the RV32I core.
- Accepts one memory-stage request at a time and returns one response per request.
- Implements LB/LH/LW/LBU/LHU and SB/SH/SW on the word-only RAM: loads use the async read port; sub-word stores use a read-merge-write sequence.

Parameters:
- MEM_DEPTH, 1024, number of XLEN-bit words in the attached lut_ram (LUT_DEPTH).
- ADDR_W, $clog2(MEM_DEPTH), RAM word-address width. Derived; do not override.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; low byte/half is used for SB/SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  XLEN  load result (extended); 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal funct3.
- ram_wr_en  out  1  to lut_ram wr_en.
- ram_wr_addr  out  ADDR_W  to lut_ram wr_addr.
- ram_wr_data  out  XLEN  to lut_ram wr_data.
- ram_rd_addr  out  ADDR_W  to lut_ram rd_addr.
- ram_rd_data  in  XLEN  from lut_ram rd_data (combinational).

Behaviour:
- Reset: async clear. State goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; latched addr/data/funct3 go to 0. ram_wr_en=0 immediately.
- Reset mid-operation: a pending store is dropped and never written. No response is produced.
- Handshake: transfer occurs on valid&&ready. req_ready=1 only in IDLE. rsp_valid holds, with rsp_rdata and rsp_err stable, until rsp_ready.
- Word address: waddr = req_addr[ADDR_W+1:2]; byte offset off = req_addr[1:0].
- Error conditions: H/HU with off[0]=1; W with off≠0; req_addr[XLEN-1:2] ≥ MEM_DEPTH; funct3 outside the legal set (011, 110, 111; store with 100/101).
- FSM IDLE:
  - ram_rd_addr = waddr of req_addr, combinational.
  - Accepted load: extract the byte/half at off from ram_rd_data; sign-extend for B/H, zero-extend for BU/HU. Register into rsp_rdata and go to RESP.
  - Accepted store: latch waddr, off, funct3, wdata; go to MERGE.
  - Accepted error: rsp_err=1, rsp_rdata=0, go to RESP, no RAM write.
- FSM MERGE (one cycle):
  - ram_rd_addr = latched waddr; ram_wr_addr = latched waddr; ram_wr_en=1.
  - ram_wr_data = ram_rd_data with the addressed byte/half replaced. SW writes wdata whole.
  - Go to RESP with rsp_rdata=0.
- FSM RESP: rsp_valid=1. On rsp_ready go to IDLE. The next request can be accepted in the following cycle.
- ram_wr_en is decoded from state only (1 only in MERGE).
- Latency:
  - Load accepted at edge N gives rsp_valid after edge N (1 cycle).
  - Store accepted at N: RAM written at edge N+1, rsp_valid after N+1.
  - A load issued after the store's response returns the new data.
- Throughput: one load per 2 cycles, one store per 3 cycles with rsp_ready held high.

Optional Feature:
- Macro LSU_MISALIGN_ERR_EN.
- Defined: misaligned accesses raise rsp_err and perform no write (as above).
- Undefined: misalignment is not an error. Low address bits are forced aligned (H: off[0]→0; W: off→00) and the access proceeds. Out-of-range and illegal-funct3 errors still apply.

Test Plan:
- After reset with no requests: rsp_valid=0, ram_wr_en=0, req_ready=1. Assert rst during MERGE of an SW → RAM word unchanged, no response.
- SW 0xDEADBEEF to 0x10, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, load response 1 cycle after accept.
- With word 0x10 = 0xDEADBEEF: SB 0x5A to 0x12 → word becomes 0xDE5ABEEF. Then LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
- SH 0x8001 to 0x16, then LH 0x16 → 0xFFFF8001; LHU 0x16 → 0x00008001. The other half of the word is untouched.
- With macro defined: LW 0x11 → rsp_err=1, rsp_rdata=0. SW to byte address 4*MEM_DEPTH → rsp_err=1, ram_wr_en never asserted.
- Hold rsp_ready=0 for 5 cycles after a load: rsp_valid and rsp_rdata stable, req_ready=0 throughout. Release → IDLE next cycle.
